// File: rtl/al_buckeye_readback_pkg.sv
// Shared Buckeye constants: word width, default bit divider and readback FSM state encoding.
package al_buckeye_readback_pkg;

    localparam int unsigned BKY_WORD_W      = 16;
    localparam int unsigned BKY_DIV_DEFAULT = 40;
    localparam int unsigned BKY_ST_W        = 2;

    typedef logic [BKY_WORD_W-1:0] bky_word_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/bky_rb_fifo.sv
// Single-clock first-word-fall-through FIFO for readback words; head word reads as 0 when empty.
module bky_rb_fifo
    import al_buckeye_readback_pkg::*;
#(
    parameter int unsigned FDEPTH = 32
) (
    input  logic                      CLK40,
    input  logic                      RST,
    input  logic                      push,
    input  logic                      pop,
    input  bky_word_t                 din,
    output bky_word_t                 dout,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(FDEPTH):0]   wcnt
);

    localparam int unsigned AW = $clog2(FDEPTH);

    bky_word_t     mem [FDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FDEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    assign wcnt    = count;

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK40) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/al_buckeye_readback.sv
// Buckeye chain readback: shifts NWORDS 16-bit words in LSB first at CLK40/DIV and buffers them.
module al_buckeye_readback
    import al_buckeye_readback_pkg::*;
#(
    parameter int unsigned NWORDS = 18,
    parameter int unsigned DIV    = BKY_DIV_DEFAULT,
    parameter int unsigned FDEPTH = 32
) (
    input  logic                      CLK40,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      CLR_DONE,
    input  logic                      SDIN,
    input  logic                      RD_EN,
    output logic                      SHCK_ENA,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      OVFL,
    output logic [BKY_WORD_W-1:0]     DOUT,
    output logic                      EMPTY,
    output logic                      FULL,
    output logic [$clog2(FDEPTH):0]   WCNT
);

    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned BW = $clog2(BKY_WORD_W);
    localparam int unsigned CW = $clog2(NWORDS + 1);

    localparam logic [TW-1:0] T_LAST   = TW'(DIV - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(DIV / 2 - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BKY_WORD_W - 1);
    localparam logic [CW-1:0] W_LAST   = CW'(NWORDS - 1);

    logic [BKY_ST_W-1:0] state;
    logic [BKY_ST_W-1:0] state_nxt;
    logic [TW-1:0]       timer;
    logic [BW-1:0]       bit_cnt;
    logic [CW-1:0]       word_cnt;
    bky_word_t           shreg;
    logic                load;
    logic                sample;
    logic                store;
    logic                done_set;
    logic                drop;
    logic                shck_q;
    logic                busy_q;
    logic                done_q;
    logic                ovfl_q;

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sample    = 1'b0;
        store     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_SHIFT;
                    load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                sample = (timer == T_SAMPLE);
                if (timer == T_LAST && bit_cnt == B_LAST) state_nxt = ST_STORE;
            end
            ST_STORE: begin
                store     = 1'b1;
                state_nxt = (word_cnt < W_LAST) ? ST_SHIFT : ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign done_set = store && (state_nxt == ST_FIN);
    assign drop     = store && FULL && !RD_EN;

    // Bit timer, bit counter, deserializer and word counter.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            timer    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else if (load) begin
            timer    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else begin
            if (state == ST_SHIFT) begin
                timer <= (timer == T_LAST) ? '0 : timer + TW'(1);
                if (timer == T_LAST) bit_cnt <= bit_cnt + BW'(1);
                if (sample) shreg <= {SDIN, shreg[BKY_WORD_W-1:1]};
            end
            if (store) word_cnt <= word_cnt + CW'(1);
        end
    end

    // Status outputs; a set event wins over a coincident clear.
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            shck_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else begin
            shck_q <= (state_nxt == ST_SHIFT);
            busy_q <= (state_nxt == ST_SHIFT) || (state_nxt == ST_STORE);
            if (done_set)      done_q <= 1'b1;
            else if (CLR_DONE) done_q <= 1'b0;
            if (drop)          ovfl_q <= 1'b1;
            else if (CLR_DONE) ovfl_q <= 1'b0;
        end
    end

    assign SHCK_ENA = shck_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign OVFL     = ovfl_q;

    bky_rb_fifo #(
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .CLK40 (CLK40),
        .RST   (RST),
        .push  (store),
        .pop   (RD_EN),
        .din   (shreg),
        .dout  (DOUT),
        .empty (EMPTY),
        .full  (FULL),
        .wcnt  (WCNT)
    );

endmodule

// File: tb/tb_al_buckeye_readback.sv
// Randomized bench for al_buckeye_readback against a cycle-indexed behavioural model of a readback.
module tb_al_buckeye_readback;

    localparam int NW     = 6;
    localparam int DV     = 4;
    localparam int FD     = 4;
    localparam int P      = 16 * DV + 1;
    localparam int T_DONE = NW * P + 1;

    logic        CLK40 = 1'b0;
    logic        RST;
    logic        START;
    logic        CLR_DONE;
    logic        SDIN;
    logic        RD_EN;
    logic        SHCK_ENA;
    logic        BUSY;
    logic        DONE;
    logic        OVFL;
    logic [15:0] DOUT;
    logic        EMPTY;
    logic        FULL;
    logic [2:0]  WCNT;

    int checks   = 0;
    int failures = 0;

    // Model: rc is the cycle index since START (START cycle = 0) of the current readback.
    logic [15:0] pat [NW];
    logic [15:0] mq [$];
    bit          running;
    int          rc;
    bit          m_done;
    bit          m_ovfl;

    always #5 CLK40 = ~CLK40;

    al_buckeye_readback #(
        .NWORDS (NW),
        .DIV    (DV),
        .FDEPTH (FD)
    ) dut (
        .CLK40    (CLK40),
        .RST      (RST),
        .START    (START),
        .CLR_DONE (CLR_DONE),
        .SDIN     (SDIN),
        .RD_EN    (RD_EN),
        .SHCK_ENA (SHCK_ENA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .OVFL     (OVFL),
        .DOUT     (DOUT),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .WCNT     (WCNT)
    );

    function automatic bit in_run();
        return running && rc >= 1 && rc <= NW * P;
    endfunction

    function automatic logic [24:0] obs_vec();
        return {SHCK_ENA, BUSY, DONE, OVFL, EMPTY, FULL, WCNT, DOUT};
    endfunction

    function automatic logic [24:0] exp_vec();
        logic shck;
        logic busy;
        logic [15:0] head;
        busy = in_run();
        shck = busy && (((rc - 1) % P) < 16 * DV);
        head = (mq.size() > 0) ? mq[0] : 16'h0;
        return {shck, busy, m_done, m_ovfl, (mq.size() == 0), (mq.size() == FD), 3'(mq.size()), head};
    endfunction

    // Drive SDIN for the current cycle, advance the model across the coming edge, then clock.
    task automatic tick();
        int r;
        int w;
        bit store;
        bit pop;
        bit drop;
        SDIN = 1'($urandom);
        if (in_run()) begin
            r = (rc - 1) % P;
            w = (rc - 1) / P;
            if (r < 16 * DV) SDIN = pat[w][r / DV];
        end
        store = in_run() && (rc % P == 0);
        pop   = RD_EN && (mq.size() > 0);
        drop  = 1'b0;
        if (RST) begin
            mq.delete();
            m_done  = 1'b0;
            m_ovfl  = 1'b0;
            running = 1'b0;
            rc      = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (store) begin
                if (mq.size() < FD) mq.push_back(pat[rc / P - 1]);
                else drop = 1'b1;
            end
            if (drop) m_ovfl = 1'b1;
            else if (CLR_DONE) m_ovfl = 1'b0;
            if (running && rc == NW * P) m_done = 1'b1;
            else if (CLR_DONE) m_done = 1'b0;
            if (START && (!running || rc >= NW * P + 2)) begin
                running = 1'b1;
                rc      = 1;
            end else if (running) begin
                rc++;
            end
        end
        @(posedge CLK40);
        #1;
    endtask

    task automatic settle();
        START    = 1'b0;
        RD_EN    = 1'b1;
        CLR_DONE = 1'b1;
        repeat (FD + 2) tick();
        RD_EN    = 1'b0;
        CLR_DONE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks += 8;
        if (SHCK_ENA !== 1'b0) begin failures++; $display("FAIL reset_shck got=%b exp=0", SHCK_ENA); end
        if (BUSY !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        if (DONE !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
        if (OVFL !== 1'b0)     begin failures++; $display("FAIL reset_ovfl got=%b exp=0", OVFL); end
        if (DOUT !== 16'h0)    begin failures++; $display("FAIL reset_dout got=%h exp=0000", DOUT); end
        if (EMPTY !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
        if (FULL !== 1'b0)     begin failures++; $display("FAIL reset_full got=%b exp=0", FULL); end
        if (WCNT !== 3'd0)     begin failures++; $display("FAIL reset_wcnt got=%0d exp=0", WCNT); end
        RST = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_readback();
        int first_done;
        settle();
        foreach (pat[i]) pat[i] = 16'($urandom);
        pat[0] = 16'h1234;
        pat[1] = 16'hABCD;
        START = 1'b1;
        tick();
        START = 1'b0;
        first_done = -1;
        for (int n = 0; n < T_DONE + 2; n++) begin
            RD_EN = (rc > 2 * P + 1) ? 1'($urandom) : (rc == 2 * P + 1);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL readback_vec rc=%0d got=%h exp=%h", rc, obs_vec(), exp_vec());
            end
            if (rc == P + 1) begin
                checks++;
                if (DOUT !== 16'h1234) begin failures++; $display("FAIL readback_word0 got=%h exp=1234", DOUT); end
            end
            if (rc == 2 * P + 2) begin
                checks++;
                if (DOUT !== 16'hABCD) begin failures++; $display("FAIL readback_word1 got=%h exp=abcd", DOUT); end
            end
            if (DONE === 1'b1 && first_done < 0) first_done = rc;
        end
        RD_EN = 1'b0;
        checks++;
        if (first_done != T_DONE) begin
            failures++;
            $display("FAIL readback_done_cycle got=%0d exp=%0d", first_done, T_DONE);
        end
    endtask

    task automatic test_overflow();
        settle();
        foreach (pat[i]) pat[i] = 16'($urandom);
        RD_EN = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 0; n < T_DONE + 1; n++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL overflow_vec rc=%0d got=%h exp=%h", rc, obs_vec(), exp_vec());
            end
        end
        checks += 4;
        if (FULL !== 1'b1)  begin failures++; $display("FAIL overflow_full got=%b exp=1", FULL); end
        if (WCNT !== 3'd4)  begin failures++; $display("FAIL overflow_wcnt got=%0d exp=4", WCNT); end
        if (OVFL !== 1'b1)  begin failures++; $display("FAIL overflow_ovfl got=%b exp=1", OVFL); end
        if (DONE !== 1'b1)  begin failures++; $display("FAIL overflow_done got=%b exp=1", DONE); end
        for (int i = 0; i < FD; i++) begin
            checks++;
            if (DOUT !== pat[i]) begin
                failures++;
                $display("FAIL overflow_drain%0d got=%h exp=%h", i, DOUT, pat[i]);
            end
            RD_EN = 1'b1;
            tick();
        end
        RD_EN = 1'b0;
        checks++;
        if (EMPTY !== 1'b1) begin failures++; $display("FAIL overflow_empty got=%b exp=1", EMPTY); end
    endtask

    task automatic test_clr_done();
        settle();
        foreach (pat[i]) pat[i] = 16'($urandom);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 0; n < T_DONE + 2; n++) begin
            CLR_DONE = (rc == NW * P) || (rc == T_DONE);
            RD_EN    = (rc == NW * P);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL clr_vec rc=%0d got=%h exp=%h", rc, obs_vec(), exp_vec());
            end
            if (rc == 5 * P + 1) begin
                checks++;
                if (OVFL !== 1'b1) begin failures++; $display("FAIL clr_ovfl_set got=%b exp=1", OVFL); end
            end
            if (rc == T_DONE) begin
                checks += 2;
                if (DONE !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", DONE); end
                if (WCNT !== 3'd4) begin failures++; $display("FAIL clr_full_pushpop got=%0d exp=4", WCNT); end
            end
            if (rc == T_DONE + 1) begin
                checks += 2;
                if (DONE !== 1'b0) begin failures++; $display("FAIL clr_done_clear got=%b exp=0", DONE); end
                if (OVFL !== 1'b0) begin failures++; $display("FAIL clr_ovfl_clear got=%b exp=0", OVFL); end
            end
        end
        CLR_DONE = 1'b0;
        RD_EN    = 1'b0;
    endtask

    task automatic test_start_ignored();
        int n_pop;
        settle();
        foreach (pat[i]) pat[i] = 16'($urandom);
        START = 1'b1;
        tick();
        n_pop = 0;
        for (int n = 0; n < T_DONE + 2; n++) begin
            START = (rc == 20) || (rc == P) || (rc == P + 30) || (rc == T_DONE);
            RD_EN = (mq.size() > 0);
            if (RD_EN && EMPTY === 1'b0) n_pop++;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL start_ign_vec rc=%0d got=%h exp=%h", rc, obs_vec(), exp_vec());
            end
        end
        START = 1'b0;
        RD_EN = 1'b0;
        checks++;
        if (n_pop != NW) begin
            failures++;
            $display("FAIL start_ign_words got=%0d exp=%0d", n_pop, NW);
        end
    endtask

    task automatic test_reset_mid();
        settle();
        foreach (pat[i]) pat[i] = 16'($urandom);
        RD_EN = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        while (rc < P + 1 + 7 * DV + 2) tick();
        RST = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0}) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=%h", obs_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0});
        end
        RST = 1'b0;
        tick();
        foreach (pat[i]) pat[i] = 16'($urandom);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 0; n < T_DONE + 2; n++) begin
            RD_EN = 1'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL midreset_rerun rc=%0d got=%h exp=%h", rc, obs_vec(), exp_vec());
            end
        end
        RD_EN = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        START    = 1'b0;
        CLR_DONE = 1'b0;
        SDIN     = 1'b0;
        RD_EN    = 1'b0;
        running  = 1'b0;
        rc       = 0;
        m_done   = 1'b0;
        m_ovfl   = 1'b0;
        test_reset();
        test_readback();
        test_overflow();
        test_clr_done();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
